apb_sin_lut_bank: RTL and testbench
===================================

Name: apb_sin_lut_bank

Overview:
- Parametrised APB3 slave holding a software-loadable sine lookup table that is shared by NUM_CH independent readout channels.
- Each channel has its own LUT index, a step increment and an auto-step mode. In auto-step mode, every RESULT read advances the index, which makes the channel a simple phase-stepping generator.
- Adds programmable wait states, sticky error status and ID registers.
- Sits on the peripheral APB bus, alongside the existing APB register slaves.

Parameters:
- DATA_W, 16: LUT entry width, signed two's complement, 2..32.
- LUT_DEPTH, 8: number of LUT entries, power of 2, 2..256. IDX_W = clog2(LUT_DEPTH).
- NUM_CH, 2: number of readout channels, 1..8.
- WAIT_STATES, 0: extra access cycles before pready, 0..15.
- ADDR_W, 12: width of paddr.

Ports:
- pclk  in  1  clock; all logic on rising edge.
- preset  in  1  synchronous active-high reset.
- paddr  in  ADDR_W  byte address; bits [1:0] ignored.
- pwdata  in  32  write data.
- psel  in  1  slave select.
- penable  in  1  access phase.
- pwrite  in  1  1 = write, 0 = read.
- pready  out  1  transfer complete; registered.
- pslverr  out  1  error response; valid only while pready=1.
- prdata  out  32  read data; valid only while pready=1, otherwise 0.

Behaviour:
- Reset (preset=1 at an edge): pready=0, pslverr=0, prdata=0, state IDLE. All CTRL, STEP, LUT entries and STATUS.err are cleared to 0. Reset wins over any transfer in flight.
- Address map (byte offsets):
  - 0x000 ID: RO, constant 32'h5A1B_0002.
  - 0x004 STATUS: bit0 err (sticky, write-1-to-clear), [15:8]=NUM_CH, [23:16]=IDX_W.
  - 0x100+ch*0x10 +0x0 CTRL: [IDX_W-1:0] index, bit16 auto.
  - 0x100+ch*0x10 +0x4 STEP: [IDX_W-1:0] step.
  - 0x100+ch*0x10 +0x8 RESULT: RO.
  - 0x800+i*4 LUT[i]: RW, low DATA_W bits; reads are sign-extended to 32.
  - Channel and LUT slots at or above NUM_CH / LUT_DEPTH are unmapped.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: psel=1 and penable=0 → WAIT, counter loaded with WAIT_STATES.
  - WAIT, psel=0: abort → IDLE, no side effects.
  - WAIT, psel=1, penable=1, cnt≠0: cnt decrements.
  - WAIT, psel=1, penable=1, cnt=0: the access is performed at this edge; pready<=1 and pslverr/prdata are loaded; → DONE.
  - DONE: pready=1 visible for exactly one cycle, then pready<=0, pslverr<=0, prdata<=0 → IDLE.
- Access phase length: WAIT_STATES+2 cycles, with pready high in the last one. Back-to-back transfers are accepted because a setup cycle always lands in IDLE.
- Errors: pslverr=1 with no register side effect in each of these cases. STATUS.err is set to 1 on each.
  - Unmapped address (read returns 0).
  - Write to ID or RESULT.
  - CTRL or STEP write with any nonzero bit in pwdata[15:IDX_W].
- RESULT read returns sign-extended LUT[index]. If auto=1, the same edge updates index <= (index+step) mod LUT_DEPTH; the wrap is a natural IDX_W-bit overflow. An error read or an aborted transfer does not step the index.
- Reads of CTRL return index and auto with all other bits 0. LUT writes take effect immediately; a following RESULT read sees the new value.
- A STATUS write of 1 to bit0 clears err. If that same write is itself erroneous, that cannot occur, because STATUS is always mapped.

Decomposition:
- Package apb_sin_pkg holds:
  - register offset constants, the ID value and the CTRL bit positions (auto=16);
  - the FSM state enum typedef;
  - the DATA_W→32 sign-extend function.
- Sub-module apb_sin_channel holds the index, step and auto registers plus the wrap adder. It takes write-enable, read-step strobes and write data, and outputs the index. It is instantiated NUM_CH times via generate.

Test Plan:
- Defaults. Write LUT[2]=0x7FFF and ch0 CTRL=0x2, then read ch0 RESULT → prdata=0x0000_7FFF, pslverr=0. Read ID → 0x5A1B_0002. Read STATUS → 0x0003_0200.
- Sign extension. Write LUT[5]=0x8F8F and ch1 CTRL=0x5, then read ch1 RESULT → 0xFFFF_8F8F.
- Auto-step with wrap. Load LUT[i]=i+0x10, set ch1 STEP=3 and ch1 CTRL=0x0001_0006, then read RESULT three times → 0x16, 0x11, 0x14. A CTRL read afterwards → 0x0001_0007.
- Errors.
  - Write ch0 CTRL=0x8 → pslverr=1, CTRL unchanged, STATUS.err=1.
  - Write RESULT → pslverr=1.
  - Read 0x7F0 → pslverr=1, prdata=0.
  - Write STATUS=1 → err=0.
- Timing.
  - WAIT_STATES=3 → pready low for 4 access cycles, then high for 1.
  - WAIT_STATES=0 → access phase is 2 cycles.
  - Drop psel in WAIT → returns to IDLE, no write happens.
- Reset mid-transfer. Assert preset during WAIT of a CTRL write → pready never rises, CTRL=0, and the next transfer completes normally.

Source files
------------

// File: rtl/apb_sin_pkg.sv
// Shared constants, FSM state type and sign-extension helper for the APB sine LUT bank.
package apb_sin_pkg;

  localparam logic [31:0] ID_VALUE      = 32'h5A1B_0002;
  localparam int          OFF_ID        = 'h000;
  localparam int          OFF_STATUS    = 'h004;
  localparam int          CH_BASE       = 'h100;
  localparam int          LUT_BASE      = 'h800;
  localparam logic [3:0]  CH_CTRL       = 4'h0;
  localparam logic [3:0]  CH_STEP       = 4'h4;
  localparam logic [3:0]  CH_RESULT     = 4'h8;
  localparam int          CTRL_AUTO_BIT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } apb_state_e;

  // v holds a zero-extended w-bit value; replicate bit w-1 into the upper bits.
  function automatic logic [31:0] sext32(input logic [31:0] v, input int w);
    sext32 = $signed(v << (32 - w)) >>> (32 - w);
  endfunction

endpackage

// File: rtl/apb_sin_channel.sv
// One readout channel: LUT index, step and auto-step flag with wrapping index advance.
module apb_sin_channel
  import apb_sin_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             ctrl_we,
  input  logic             step_we,
  input  logic             rd_step,
  input  logic [IDX_W-1:0] wr_index,
  input  logic             wr_auto,
  output logic [IDX_W-1:0] index,
  output logic [IDX_W-1:0] step,
  output logic             auto_mode
);

  always_ff @(posedge pclk) begin
    if (preset) begin
      index     <= '0;
      step      <= '0;
      auto_mode <= 1'b0;
    end else begin
      if (ctrl_we) begin
        index     <= wr_index;
        auto_mode <= wr_auto;
      end else if (rd_step && auto_mode) begin
        // IDX_W-bit add wraps modulo the LUT depth by construction.
        index <= index + step;
      end
      if (step_we) step <= wr_index;
    end
  end

endmodule

// File: rtl/apb_sin_lut_bank.sv
// APB3 slave: software-loaded sine LUT shared by NUM_CH index/step readout channels.
module apb_sin_lut_bank
  import apb_sin_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int LUT_DEPTH   = 8,
  parameter int NUM_CH      = 2,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 12
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  output logic              pready,
  output logic              pslverr,
  output logic [31:0]       prdata,
  output logic [1:0]        state_dbg
);

  // Handshake: setup cycle (psel=1, penable=0) is taken in IDLE; the access is
  // performed once penable=1 and the wait counter is exhausted, and pready is
  // high for exactly one cycle afterwards. Dropping psel before that aborts.

  localparam int IDX_W = $clog2(LUT_DEPTH);

  apb_state_e        state;
  logic [3:0]        cnt;
  logic              err_q;
  logic [DATA_W-1:0] lut [LUT_DEPTH];

  logic [ADDR_W-1:0] addr;
  logic [3:0]        ch_num, ch_reg;
  logic [7:0]        lut_slot;
  logic [IDX_W-1:0]  lut_idx;
  logic              is_id, is_status, ch_region, ch_hit, lut_region, lut_hit;
  logic              wr_field_bad, acc_err, do_access, wr_ok, rd_ok;
  logic [31:0]       rd_data;
  logic [IDX_W-1:0]  sel_index, sel_step;
  logic              sel_auto;

  logic [IDX_W-1:0]  ch_index [NUM_CH];
  logic [IDX_W-1:0]  ch_step  [NUM_CH];
  logic              ch_auto  [NUM_CH];
  logic [NUM_CH-1:0] ctrl_we, step_we, rd_step;
  logic              unused_ok;

  assign unused_ok  = &{1'b0, pwdata, paddr[1:0]};
  assign state_dbg  = state;
  assign addr       = {paddr[ADDR_W-1:2], 2'b00};
  assign ch_num     = addr[7:4];
  assign ch_reg     = addr[3:0];
  assign lut_slot   = addr[9:2];
  assign lut_idx    = lut_slot[IDX_W-1:0];
  assign is_id      = addr == ADDR_W'(OFF_ID);
  assign is_status  = addr == ADDR_W'(OFF_STATUS);
  assign ch_region  = addr[ADDR_W-1:8] == (ADDR_W-8)'(CH_BASE >> 8);
  assign ch_hit     = 32'(ch_num) < NUM_CH;
  assign lut_region = addr[ADDR_W-1:10] == (ADDR_W-10)'(LUT_BASE >> 10);
  assign lut_hit    = 32'(lut_slot) < LUT_DEPTH;
  assign wr_field_bad = |(pwdata[15:0] >> IDX_W);

  assign do_access = (state == ST_WAIT) && psel && penable && (cnt == 4'd0);
  assign wr_ok     = do_access && pwrite && !acc_err;
  assign rd_ok     = do_access && !pwrite && !acc_err;

  always_comb begin
    sel_index = '0;
    sel_step  = '0;
    sel_auto  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_num == 4'(c)) begin
        sel_index = ch_index[c];
        sel_step  = ch_step[c];
        sel_auto  = ch_auto[c];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    acc_err = 1'b0;
    if (is_id) begin
      rd_data = ID_VALUE;
      acc_err = pwrite;
    end else if (is_status) begin
      rd_data = {8'd0, 8'(IDX_W), 8'(NUM_CH), 7'd0, err_q};
    end else if (ch_region && ch_hit) begin
      case (ch_reg)
        CH_CTRL: begin
          rd_data = 32'(sel_index) | (32'(sel_auto) << CTRL_AUTO_BIT);
          acc_err = pwrite && wr_field_bad;
        end
        CH_STEP: begin
          rd_data = 32'(sel_step);
          acc_err = pwrite && wr_field_bad;
        end
        CH_RESULT: begin
          rd_data = sext32(32'(lut[sel_index]), DATA_W);
          acc_err = pwrite;
        end
        default: acc_err = 1'b1;
      endcase
    end else if (lut_region && lut_hit) begin
      rd_data = sext32(32'(lut[lut_idx]), DATA_W);
    end else begin
      acc_err = 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic ch_sel;
    assign ch_sel     = ch_region && (ch_num == 4'(c));
    assign ctrl_we[c] = wr_ok && ch_sel && (ch_reg == CH_CTRL);
    assign step_we[c] = wr_ok && ch_sel && (ch_reg == CH_STEP);
    assign rd_step[c] = rd_ok && ch_sel && (ch_reg == CH_RESULT);

    apb_sin_channel #(.IDX_W(IDX_W)) u_ch (
      .pclk      (pclk),
      .preset    (preset),
      .ctrl_we   (ctrl_we[c]),
      .step_we   (step_we[c]),
      .rd_step   (rd_step[c]),
      .wr_index  (pwdata[IDX_W-1:0]),
      .wr_auto   (pwdata[CTRL_AUTO_BIT]),
      .index     (ch_index[c]),
      .step      (ch_step[c]),
      .auto_mode (ch_auto[c])
    );
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
    end else if (wr_ok && lut_region) begin
      lut[lut_idx] <= pwdata[DATA_W-1:0];
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (psel && !penable) begin
            state <= ST_WAIT;
            cnt   <= 4'(WAIT_STATES);
          end
        end
        ST_WAIT: begin
          if (!psel) begin
            state <= ST_IDLE;
          end else if (penable) begin
            if (cnt != 4'd0) begin
              cnt <= cnt - 4'd1;
            end else begin
              pready  <= 1'b1;
              pslverr <= acc_err;
              prdata  <= (pwrite || acc_err) ? 32'd0 : rd_data;
              state   <= ST_DONE;
              if (acc_err) err_q <= 1'b1;
              else if (pwrite && is_status && pwdata[0]) err_q <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_sin_lut_bank.sv
// Scoreboard bench for apb_sin_lut_bank: zero-wait instance A plus a 3-wait-state instance B.
module tb_apb_sin_lut_bank;

  localparam int EW = 42; // {check_data, exp_err, exp_data[31:0], exp_cycles[7:0]}

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic        psel_a = 1'b0, psel_b = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic        pready_a, pslverr_a, pready_b, pslverr_b;
  logic [31:0] prdata_a, prdata_b;
  logic [1:0]  state_dbg_a, state_dbg_b;

  logic [EW-1:0] exp_q[$];
  int errors = 0, checks = 0;
  int acc_cnt = 0;
  int timeout_req = 0, timeout_seen = 0;
  logic idle_chk = 1'b0;

  always #5 pclk = ~pclk;

  apb_sin_lut_bank #(.WAIT_STATES(0)) dut_a (
    .pclk(pclk), .preset(preset), .paddr(paddr), .pwdata(pwdata),
    .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .pready(pready_a), .pslverr(pslverr_a), .prdata(prdata_a), .state_dbg(state_dbg_a)
  );

  apb_sin_lut_bank #(.WAIT_STATES(3)) dut_b (
    .pclk(pclk), .preset(preset), .paddr(paddr), .pwdata(pwdata),
    .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .pready(pready_b), .pslverr(pslverr_b), .prdata(prdata_b), .state_dbg(state_dbg_b)
  );

  // Monitor: counts access cycles and checks every completed transfer against the queue.
  logic [EW-1:0] e;
  logic          cur_err;
  logic [31:0]   cur_data;
  always @(negedge pclk) begin
    if (preset) begin
      acc_cnt = 0;
    end else begin
      if ((psel_a || psel_b) && penable) acc_cnt++;
      else acc_cnt = 0;
      if (pready_a || pready_b) begin
        cur_err  = pready_a ? pslverr_a : pslverr_b;
        cur_data = pready_a ? prdata_a : prdata_b;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pready addr=%h got pready=1 want 0", paddr);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (cur_err !== e[40]) begin
            errors++;
            $display("FAIL pslverr addr=%h got=%0b want=%0b", paddr, cur_err, e[40]);
          end
          if (e[41]) begin
            checks++;
            if (cur_data !== e[39:8]) begin
              errors++;
              $display("FAIL prdata addr=%h got=%h want=%h", paddr, cur_data, e[39:8]);
            end
          end
          if (e[7:0] != 8'd0) begin
            checks++;
            if (acc_cnt != int'(e[7:0])) begin
              errors++;
              $display("FAIL access_cycles addr=%h got=%0d want=%0d", paddr, acc_cnt, e[7:0]);
            end
          end
        end
        acc_cnt = 0;
      end
      if (idle_chk) begin
        checks++;
        if ({pready_a, pslverr_a, prdata_a, pready_b, pslverr_b, prdata_b} !== '0) begin
          errors++;
          $display("FAIL idle_outputs got a=%b/%b/%h b=%b/%b/%h want all 0",
                   pready_a, pslverr_a, prdata_a, pready_b, pslverr_b, prdata_b);
        end
      end
      if (timeout_req != timeout_seen) begin
        timeout_seen = timeout_req;
        checks++; errors++;
        $display("FAIL pready_timeout addr=%h got no pready want pready within 40 cycles", paddr);
      end
    end
  end

  task automatic xfer(input bit b, input bit wr, input logic [11:0] addr,
                      input logic [31:0] wd, input bit eerr, input bit chk,
                      input logic [31:0] edata, input logic [7:0] ecyc);
    int  n;
    bit  got;
    exp_q.push_back({chk, eerr, edata, ecyc});
    @(posedge pclk); #1;
    psel_a = !b; psel_b = b; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge pclk);
      got = b ? pready_b : pready_a;
      n++;
    end
    if (!got) begin
      void'(exp_q.pop_back());
      timeout_req++;
    end
    @(posedge pclk); #1;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
  endtask

  task automatic wr_a(input logic [11:0] a, input logic [31:0] d);
    xfer(1'b0, 1'b1, a, d, 1'b0, 1'b0, 32'd0, 8'd2);
  endtask
  task automatic wr_err_a(input logic [11:0] a, input logic [31:0] d);
    xfer(1'b0, 1'b1, a, d, 1'b1, 1'b0, 32'd0, 8'd2);
  endtask
  task automatic rd_a(input logic [11:0] a, input logic [31:0] exp_d);
    xfer(1'b0, 1'b0, a, 32'd0, 1'b0, 1'b1, exp_d, 8'd2);
  endtask
  task automatic rd_err_a(input logic [11:0] a);
    xfer(1'b0, 1'b0, a, 32'd0, 1'b1, 1'b1, 32'd0, 8'd2);
  endtask

  task automatic idle_cycles(input int n);
    @(posedge pclk); #1;
    idle_chk = 1'b1;
    repeat (n) @(posedge pclk);
    #1;
    idle_chk = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    idle_cycles(2);

    // Defaults
    wr_a(12'h808, 32'h0000_7FFF);
    wr_a(12'h100, 32'h0000_0002);
    rd_a(12'h108, 32'h0000_7FFF);
    rd_a(12'h000, 32'h5A1B_0002);
    rd_a(12'h004, 32'h0003_0200);

    // Sign extension
    wr_a(12'h814, 32'h0000_8F8F);
    wr_a(12'h110, 32'h0000_0005);
    rd_a(12'h118, 32'hFFFF_8F8F);
    rd_a(12'h814, 32'hFFFF_8F8F);

    // Auto-step with wrap: index 6 -> 1 -> 4 -> 7
    for (int i = 0; i < 8; i++) wr_a(12'h800 + 12'(4 * i), 32'(i + 'h10));
    wr_a(12'h114, 32'h0000_0003);
    rd_a(12'h114, 32'h0000_0003);
    wr_a(12'h110, 32'h0001_0006);
    rd_a(12'h118, 32'h0000_0016);
    rd_a(12'h118, 32'h0000_0011);
    rd_a(12'h118, 32'h0000_0014);
    rd_a(12'h110, 32'h0001_0007);

    // Errors
    wr_err_a(12'h100, 32'h0000_0008);
    rd_a(12'h100, 32'h0000_0002);
    rd_a(12'h004, 32'h0003_0201);
    wr_err_a(12'h118, 32'h0000_0001);
    rd_a(12'h110, 32'h0001_0007);
    wr_err_a(12'h000, 32'h0000_0000);
    rd_err_a(12'h7F0);
    rd_err_a(12'h120);
    rd_err_a(12'h820);
    wr_a(12'h004, 32'h0000_0001);
    rd_a(12'h004, 32'h0003_0200);

    // Timing on the 3-wait-state instance: 5 access cycles
    xfer(1'b1, 1'b0, 12'h000, 32'd0, 1'b0, 1'b1, 32'h5A1B_0002, 8'd5);

    // Abort in WAIT on instance B: no write, no pready
    @(posedge pclk); #1;
    psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h100; pwdata = 32'h3;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel_b = 1'b0; penable = 1'b0;
    idle_cycles(3);
    xfer(1'b1, 1'b0, 12'h100, 32'd0, 1'b0, 1'b1, 32'h0000_0000, 8'd5);

    // Reset during WAIT of a CTRL write on instance A
    @(posedge pclk); #1;
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h100; pwdata = 32'h5;
    @(posedge pclk); #1;
    penable = 1'b1; preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0; psel_a = 1'b0; penable = 1'b0;
    idle_cycles(3);
    rd_a(12'h100, 32'h0000_0000);
    rd_a(12'h808, 32'h0000_0000);
    wr_a(12'h808, 32'h0000_1234);
    rd_a(12'h808, 32'h0000_1234);

    repeat (3) @(posedge pclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
